// File: rtl/oci_dct_pkg.sv
// Shared types and helpers for the OCI data-capture-trace (DCT) capture block.
// Contents:
//   state_e      - capture FSM states RUN / DRAIN / ENDED
//   TS_W         - width of the optional capture timestamp
//   TS_FIELD_W   - width the timestamp adds to each FIFO entry (0 when the
//                  OCI_DCT_TIMESTAMP_EN macro is undefined)
//   sat_inc      - saturating increment
//   clamp_count  - limits a requested lane count to the lanes available
package oci_dct_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_e;

  localparam int TS_W = 16;

`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int TS_FIELD_W = TS_W;
`else
  localparam int TS_FIELD_W = 0;
`endif

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned lanes);
    return (cnt > lanes) ? lanes : cnt;
  endfunction

endpackage

// File: rtl/oci_dct_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on pop_data_o
// whenever empty_o is low. A push is taken while full if a pop happens in the
// same cycle. Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   push_i, push_data_i - write request and data
//   pop_i               - read request (ignored when empty)
//   pop_data_o          - head entry
//   full_o, empty_o     - occupancy flags
//   level_o             - current occupancy, 0..DEPTH
module oci_dct_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible once level_q covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/oci_dct_capture.sv
// Per-core OCI DCT capture hook. Captures a packed multi-lane trace word,
// serialises its valid lanes (lane 0 first) through a holding register into a
// show-ahead FIFO, drains the FIFO over a valid/ready stream, counts dropped
// words (saturating) and performs an end-of-test drain before raising
// test_has_ended.
// Optional feature: macro OCI_DCT_TIMESTAMP_EN adds a free-running 16-bit
// cycle counter; every lane carries the counter value of its capture edge and
// out_data becomes {timestamp, entry}.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   dct_valid         - capture strobe (no backpressure)
//   dct_buffer        - LANES packed lanes, lane 0 in the low bits
//   dct_count         - number of valid lanes, clamped to LANES
//   test_ending       - request end-of-test drain
//   out_valid/out_ready/out_data - output stream, FIFO head
//   fill_level        - FIFO occupancy
//   drop_count        - saturating count of words lost
//   test_has_ended    - sticky done flag (high only in ENDED)
//   dbg_state         - FSM state (0 RUN, 1 DRAIN, 2 ENDED)
// Stream handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and out_data
// holds steady while out_valid is high and out_ready is low.
module oci_dct_capture
  import oci_dct_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int LANES   = 3,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int DROP_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dct_valid,
  input  logic [LANES*ENTRY_W-1:0]      dct_buffer,
  input  logic [CNT_W-1:0]              dct_count,
  input  logic                          test_ending,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ENTRY_W+TS_FIELD_W-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]    fill_level,
  output logic [DROP_W-1:0]             drop_count,
  output logic                          test_has_ended,
  output logic [1:0]                    dbg_state
);

  localparam int OUT_W = ENTRY_W + TS_FIELD_W;
  localparam int REM_W = $clog2(LANES+1);

  state_e                   state_q, state_d;
  logic [LANES*ENTRY_W-1:0] hold_data_q, hold_data_d;
  logic [REM_W-1:0]         hold_rem_q, hold_rem_d;
  logic [DROP_W-1:0]        drop_q, drop_d;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, accept;
  logic [OUT_W-1:0]         push_data;

`ifdef OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, hold_ts_q, hold_ts_d;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  assign push_data = {hold_ts_q, hold_data_q[ENTRY_W-1:0]};
`else
  assign push_data = hold_data_q[ENTRY_W-1:0];
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // The holding register always offers its lowest remaining lane.
  assign push      = (hold_rem_q != '0) && (!fifo_full || pop);
  // A new word may land when the holding register is free now or will be
  // free after this cycle's push of its last lane.
  assign accept    = (state_q == RUN) && dct_valid &&
                     ((hold_rem_q == '0) || ((hold_rem_q == REM_W'(1)) && push));

  always_comb begin
    hold_data_d = hold_data_q;
    hold_rem_d  = hold_rem_q;
`ifdef OCI_DCT_TIMESTAMP_EN
    hold_ts_d   = hold_ts_q;
`endif
    if (push) begin
      hold_data_d = hold_data_q >> ENTRY_W;
      hold_rem_d  = hold_rem_q - REM_W'(1);
    end
    if (accept) begin
      hold_data_d = dct_buffer;
      hold_rem_d  = REM_W'(clamp_count(32'(dct_count), LANES));
`ifdef OCI_DCT_TIMESTAMP_EN
      hold_ts_d   = ts_q;
`endif
    end
  end

  always_comb begin
    drop_d = drop_q;
    if ((state_q == RUN) && dct_valid && !accept) begin
      drop_d = DROP_W'(sat_inc(32'(drop_q), 32'((1 << DROP_W) - 1)));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (test_ending) state_d = DRAIN;
      DRAIN:   if ((hold_rem_q == '0) && fifo_empty) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      hold_data_q <= '0;
      hold_rem_q  <= '0;
      drop_q      <= '0;
`ifdef OCI_DCT_TIMESTAMP_EN
      hold_ts_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_rem_q  <= hold_rem_d;
      drop_q      <= drop_d;
`ifdef OCI_DCT_TIMESTAMP_EN
      hold_ts_q   <= hold_ts_d;
`endif
    end
  end

  oci_dct_fifo #(
    .DATA_W (OUT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fill_level)
  );

  assign drop_count     = drop_q;
  assign test_has_ended = (state_q == ENDED);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_oci_dct_capture.sv
module tb_oci_dct_capture;

  localparam int ENTRY_W = 10;
  localparam int LANES   = 3;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int DROP_W  = 8;
  localparam int OUT_W   = ENTRY_W + oci_dct_pkg::TS_FIELD_W;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                       clk;
  logic                       reset;
  logic                       dct_valid;
  logic [LANES*ENTRY_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]           dct_count;
  logic                       test_ending;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] fill_level;
  logic [DROP_W-1:0]          drop_count;
  logic                       test_has_ended;
  logic [1:0]                 dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: lanes waiting to enter the FIFO, FIFO contents, drop
  // count, phase (0 running, 1 draining, 2 ended) and cycles since reset.
  logic [31:0] m_pend[$];
  logic [31:0] m_fifo[$];
  int          m_drop;
  int          m_phase;
  int          m_cyc;

  oci_dct_capture #(
    .ENTRY_W (ENTRY_W),
    .LANES   (LANES),
    .CNT_W   (CNT_W),
    .DEPTH   (DEPTH),
    .DROP_W  (DROP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fill_level     (fill_level),
    .drop_count     (drop_count),
    .test_has_ended (test_has_ended),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_entry(input int k);
    logic [31:0] word;
    logic [31:0] lane;
    word = 32'(dct_buffer);
    lane = (word >> (k * ENTRY_W)) & ((32'd1 << ENTRY_W) - 32'd1);
`ifdef OCI_DCT_TIMESTAMP_EN
    lane = lane | (32'(m_cyc & 16'hFFFF) << ENTRY_W);
`endif
    return lane;
  endfunction

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit pop, push, acc, all_empty;
    int n;
    if (reset) begin
      m_pend.delete();
      m_fifo.delete();
      m_drop  = 0;
      m_phase = 0;
      m_cyc   = 0;
      return;
    end
    pop       = (m_fifo.size() > 0) && out_ready;
    push      = (m_pend.size() > 0) && ((m_fifo.size() < DEPTH) || pop);
    acc       = (m_phase == 0) && dct_valid &&
                ((m_pend.size() == 0) || ((m_pend.size() == 1) && push));
    all_empty = (m_pend.size() == 0) && (m_fifo.size() == 0);
    if (pop)  void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(m_pend.pop_front());
    if (acc) begin
      n = (int'(dct_count) > LANES) ? LANES : int'(dct_count);
      for (int k = 0; k < n; k++) m_pend.push_back(lane_entry(k));
    end
    if ((m_phase == 0) && dct_valid && !acc && (m_drop < DROP_MAX)) m_drop++;
    if ((m_phase == 0) && test_ending) m_phase = 1;
    else if ((m_phase == 1) && all_empty) m_phase = 2;
    m_cyc = (m_cyc + 1) & 16'hFFFF;
  endtask

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
    check("fill_level", 32'(fill_level), 32'(m_fifo.size()));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("test_has_ended", 32'(test_has_ended), 32'(m_phase == 2));
    check("state", 32'(dbg_state), 32'(m_phase));
    if (m_fifo.size() > 0) check("out_data", 32'(out_data), m_fifo[0]);
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] buf_v, input int cnt, input bit end_v, input bit rdy);
    dct_valid   = v;
    dct_buffer  = (LANES*ENTRY_W)'(buf_v);
    dct_count   = CNT_W'(cnt);
    test_ending = end_v;
    out_ready   = rdy;
  endtask

  function automatic logic [31:0] pack3(input int l0, input int l1, input int l2);
    return (32'(l2) << (2*ENTRY_W)) | (32'(l1) << ENTRY_W) | 32'(l0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    do_reset();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_state", 32'(dbg_state), 0);

    // Basic word: lanes 1,2,3 appear on consecutive cycles, first at E1.
    drive(1, pack3(1, 2, 3), 3, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    check("no_valid_at_e0", 32'(out_valid), 0);
    cycle();
    check("first_valid_e1", 32'(out_valid), 1);
    check("first_word", 32'(out_data) & 32'h3FF, 32'h001);
    cycle();
    check("second_word", 32'(out_data) & 32'h3FF, 32'h002);
    cycle();
    check("third_word", 32'(out_data) & 32'h3FF, 32'h003);
    repeat (3) cycle();

    // Backpressure: fill the FIFO, stall the serialiser, drop extra strobes.
    for (int i = 0; i < 30; i++) begin
      drive(1, $urandom(), 3, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    cycle();
    check("fifo_full_level", 32'(fill_level), 32'(DEPTH));
    check("drops_seen", 32'(drop_count != 0), 1);
    drive(0, 0, 0, 0, 1);
    repeat (25) cycle();
    check("drained_empty", 32'(out_valid), 0);

    // Count 0 is swallowed silently; count 9 clamps to 3 lanes.
    drive(1, $urandom(), 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();
    check("count0_no_write", 32'(fill_level), 0);
    drive(1, $urandom(), 9, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (5) cycle();
    check("count9_writes", 32'(fill_level), 3);

    // Saturating drop counter.
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom(), 3, 0, 0);
      cycle();
    end
    check("drop_saturated", 32'(drop_count), 32'(DROP_MAX));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 1) == 1), $urandom(), $urandom_range(0, 15), 0,
            ($urandom_range(0, 3) != 0));
      cycle();
    end

    // End-of-test drain with a word captured on the same cycle.
    do_reset();
    drive(1, $urandom(), 3, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();
    drive(1, $urandom(), 2, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();
    check("five_queued", 32'(fill_level), 5);
    drive(1, $urandom(), 3, 1, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 50 && !test_has_ended; i++) cycle();
    check("ended_reached", 32'(test_has_ended), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom(), 3, 0, 1);
      cycle();
    end
    check("ended_sticky", 32'(test_has_ended), 1);
    check("no_drop_after_end", 32'(drop_count), 0);

    // Reset in the middle of a drain.
    do_reset();
    drive(1, $urandom(), 3, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    repeat (4) cycle();
    check("in_drain", 32'(dbg_state), 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_drain_valid", 32'(out_valid), 0);
    check("rst_drain_level", 32'(fill_level), 0);
    check("rst_drain_drop", 32'(drop_count), 0);
    check("rst_drain_ended", 32'(test_has_ended), 0);
    check("rst_drain_state", 32'(dbg_state), 0);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
